// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3-style slave that terminates the AR/R/AW/W/B channels coming from the
//   CPU's SRAM-like-to-AXI adapter. It drives a single-port synchronous SRAM
//   that has a 1-cycle read latency. It serves one transaction at a time,
//   either a single beat or an INCR/FIXED burst of up to 16 beats.
//   When AR and AW are both valid, the grant alternates between them.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   ar*/r*                 read address / read response channels
//   aw*/w*/b*              write address / data / response channels
//   sram_en, sram_wen      SRAM strobe and byte write enables (wen==0 -> read)
//   sram_addr, sram_wdata  SRAM word address and write data
//   sram_rdata             SRAM read data, valid the cycle after a read strobe
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [3:0]            arid,
    input  logic [31:0]           araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [3:0]            rid,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [3:0]            awid,
    input  logic [31:0]           awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [3:0]            bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  sram_en,
    output logic [3:0]            sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP} state_t;

    state_t                state;
    logic                  last_was_write;
    logic [3:0]            id_q, len_q, beat_q;
    logic [ADDR_WIDTH-1:0] waddr_q;     // word address; wraps naturally
    logic                  fixed_q;
    logic                  err_q;
    logic                  rd_first;    // first cycle of RD_RESP: SRAM data is live
    logic [31:0]           rdata_q;

    logic                  w_hs, beat_last, wlast_bad;
    logic [ADDR_WIDTH-1:0] waddr_next;

    // Size is always treated as 4 bytes; sub-word and out-of-range address
    // bits do not select anything.
    logic unused_ok;
    assign unused_ok = ^{arsize, awsize, araddr[1:0], araddr[31:ADDR_WIDTH+2],
                         awaddr[1:0], awaddr[31:ADDR_WIDTH+2]};

    // Write wins a tie unless the last granted transaction was a write.
    assign awready = resetn && (state == IDLE) && awvalid && (!arvalid || !last_was_write);
    assign arready = resetn && (state == IDLE) && arvalid && !awready;

    assign w_hs       = (state == WR_DATA) && wvalid && wready;
    assign beat_last  = (beat_q == len_q);
    assign wlast_bad  = (wlast != beat_last);
    assign waddr_next = fixed_q ? waddr_q : waddr_q + ADDR_WIDTH'(1);

    assign sram_en    = (state == RD_REQ) || w_hs;
    assign sram_wen   = w_hs ? wstrb : 4'b0000;
    assign sram_addr  = waddr_q;
    assign sram_wdata = wdata;

    // The SRAM output is only guaranteed in the cycle after the strobe.
    // So it is passed straight through in that cycle and held from rdata_q
    // afterwards. This keeps rdata stable while the master stalls.
    assign rdata = rd_first ? sram_rdata : rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            last_was_write <= 1'b0;
            id_q           <= '0;
            len_q          <= '0;
            beat_q         <= '0;
            waddr_q        <= '0;
            fixed_q        <= 1'b0;
            err_q          <= 1'b0;
            rd_first       <= 1'b0;
            rdata_q        <= '0;
            rvalid         <= 1'b0;
            rid            <= '0;
            rresp          <= '0;
            rlast          <= 1'b0;
            wready         <= 1'b0;
            bvalid         <= 1'b0;
            bid            <= '0;
            bresp          <= '0;
        end else begin
            rd_first <= 1'b0;
            case (state)
                IDLE: begin
                    if (awready) begin
                        id_q    <= awid;
                        waddr_q <= awaddr[ADDR_WIDTH+1:2];
                        len_q   <= awlen;
                        fixed_q <= (awburst == 2'b00);
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        wready  <= 1'b1;
                        state   <= WR_DATA;
                    end else if (arready) begin
                        id_q    <= arid;
                        waddr_q <= araddr[ADDR_WIDTH+1:2];
                        len_q   <= arlen;
                        fixed_q <= (arburst == 2'b00);
                        beat_q  <= '0;
                        state   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    rd_first <= 1'b1;
                    rvalid   <= 1'b1;
                    rid      <= id_q;
                    rresp    <= 2'b00;
                    rlast    <= beat_last;
                    state    <= RD_RESP;
                end
                RD_RESP: begin
                    if (rd_first) rdata_q <= sram_rdata;
                    if (rready) begin
                        rvalid <= 1'b0;
                        if (beat_last) begin
                            last_was_write <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 4'd1;
                            waddr_q <= waddr_next;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        // The burst ends on the beat count. A wlast that
                        // disagrees only flags SLVERR.
                        if (beat_last) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= (err_q || wlast_bad) ? 2'b10 : 2'b00;
                            state  <= WR_RESP;
                        end else begin
                            err_q   <= err_q | wlast_bad;
                            beat_q  <= beat_q + 4'd1;
                            waddr_q <= waddr_next;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid         <= 1'b0;
                        last_was_write <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//   Directed bench for axi_sram_slave. It models a 64K-word synchronous SRAM
//   with 1-cycle read latency and drives short AXI sequences. Each result is
//   compared against a hand-computed constant.
module tb_axi_sram_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  arid, arlen, awid, awlen;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, awvalid, awready;
    logic [3:0]  rid, bid;
    logic [31:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] gd [16];
    logic        gl [16];
    logic [31:0] wd [16];
    int          rfirst, strobes;
    logic [3:0]  s_wen;
    logic [31:0] s_addr, s_wdata;

    always #5 clk = ~clk;

    // SRAM model
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen == 4'b0000) sram_rdata <= mem[sram_addr];
            else for (int b = 0; b < 4; b++)
                if (sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    axi_sram_slave #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_addr(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2;
        arvalid = 1'b1;
        #1 chk("arready", {31'd0, arready}, 32'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic wr_addr(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2;
        awvalid = 1'b1;
        #1 chk("awready", {31'd0, awready}, 32'd1);
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    // Collects len+1 beats into gd/gl. With stall set, the first cycle of
    // every beat is refused, and the held data must not move.
    task automatic rd_data(input logic [3:0] id, input logic [3:0] len, input bit stall);
        int beats = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] held = '0;
        rfirst = -1;
        rready = 1'b1;
        while (beats <= int'(len) && cyc < 100) begin
            if (rvalid) begin
                if (rfirst < 0) rfirst = cyc;
                if (stall && !stalled) begin
                    rready = 1'b0; held = rdata; stalled = 1;
                end else begin
                    if (stalled) chk("r_stable", rdata, held);
                    rready = 1'b1;
                    gd[beats] = rdata;
                    gl[beats] = rlast;
                    chk("rid", {28'd0, rid}, {28'd0, id});
                    chk("rresp", {30'd0, rresp}, 32'd0);
                    beats++;
                    stalled = 0;
                end
            end
            tick();
            cyc++;
        end
        if (beats <= int'(len)) chk("r_timeout", beats, int'(len) + 1);
        rready = 1'b1;
    endtask

    task automatic wr_data(input logic [3:0] len, input logic [3:0] strb, input logic [15:0] wl);
        int n;
        strobes = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = strb; wlast = wl[i];
            n = 0;
            while (!wready && n < 20) begin tick(); n++; end
            if (n == 20) chk("wready_timeout", {31'd0, wready}, 32'd1);
            #1;
            if (sram_en) strobes++;
            if (i == 0) begin s_wen = sram_wen; s_addr = {16'd0, sram_addr}; s_wdata = sram_wdata; end
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        mem[16'h10] = 32'hDEADBEEF;
        mem[16'h20] = 32'hAABBCCDD;
        for (int i = 0; i < 4; i++) mem[16'h40 + i] = 32'hA0A0_0000 + i;

        resetn = 1'b0;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
        rready = 1'b1; bready = 1'b1;
        arvalid = 1'b1; awvalid = 1'b1;
        #12;
        // reset state
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_rvalid",  {31'd0, rvalid}, 32'd0);
        chk("rst_bvalid",  {31'd0, bvalid}, 32'd0);
        chk("rst_wready",  {31'd0, wready}, 32'd0);
        chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        arvalid = 1'b0; awvalid = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        tick();

        // single read, word 0x10
        rd_addr(4'd5, 32'h40, 4'd0, 2'b01);
        chk("rdreq_en",   {31'd0, sram_en}, 32'd1);
        chk("rdreq_wen",  {28'd0, sram_wen}, 32'd0);
        chk("rdreq_addr", {16'd0, sram_addr}, 32'h10);
        rd_data(4'd5, 4'd0, 1'b0);
        chk("rd1_data",  gd[0], 32'hDEADBEEF);
        chk("rd1_last",  {31'd0, gl[0]}, 32'd1);
        chk("rd1_lat",   rfirst, 1);

        // partial-strobe write to word 0x20, then read back
        wr_addr(4'd3, 32'h80, 4'd0, 2'b01);
        wd[0] = 32'h11223344;
        wr_data(4'd0, 4'b0101, 16'h0001);
        chk("wr1_strobes", strobes, 1);
        chk("wr1_wen",     {28'd0, s_wen}, 32'h5);
        chk("wr1_addr",    s_addr, 32'h20);
        chk("wr1_wdata",   s_wdata, 32'h11223344);
        chk("wr1_bresp",   {30'd0, bresp}, 32'd0);
        chk("wr1_bid",     {28'd0, bid}, 32'd3);
        tick();
        chk("wr1_bdrop",   {31'd0, bvalid}, 32'd0);
        rd_addr(4'd1, 32'h80, 4'd0, 2'b01);
        rd_data(4'd1, 4'd0, 1'b0);
        chk("wr1_rback",   gd[0], 32'hAA22CC44);

        // INCR burst of 4 with stalls
        rd_addr(4'd7, 32'h100, 4'd3, 2'b01);
        rd_data(4'd7, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("burst_data", gd[i], 32'hA0A0_0000 + i);
            chk("burst_last", {31'd0, gl[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // early wlast on a 2-beat write -> both beats written, SLVERR
        wr_addr(4'd2, 32'h200, 4'd1, 2'b01);
        wd[0] = 32'hCAFEF00D; wd[1] = 32'h12345678;
        wr_data(4'd1, 4'hF, 16'h0003);
        chk("wr2_strobes", strobes, 2);
        chk("wr2_bresp",   {30'd0, bresp}, 32'd2);
        tick();
        chk("wr2_mem0", mem[16'h80], 32'hCAFEF00D);
        chk("wr2_mem1", mem[16'h81], 32'h12345678);

        // arbitration after reset: write, read, write
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            arid = 4'd4; araddr = 32'h40; arlen = 4'd0; arburst = 2'b01;
            awid = 4'd9; awaddr = 32'h300; awlen = 4'd0; awburst = 2'b01;
            arvalid = 1'b1; awvalid = 1'b1;
            #1;
            chk("tie_awready", {31'd0, awready}, (k == 1) ? 32'd0 : 32'd1);
            chk("tie_arready", {31'd0, arready}, (k == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1 arvalid = 1'b0; awvalid = 1'b0;
            if (k == 1) begin
                rd_data(4'd4, 4'd0, 1'b0);
                chk("tie_rdata", gd[0], 32'hDEADBEEF);
            end else begin
                wd[0] = 32'h0BADCAFE + k;
                wr_data(4'd0, 4'hF, 16'h0001);
                chk("tie_bid", {28'd0, bid}, 32'd9);
                tick();
            end
        end
        chk("tie_mem", mem[16'hC0], 32'h0BADCB00);

        // asynchronous reset while a read response is pending
        rd_addr(4'd6, 32'h40, 4'd0, 2'b01);
        rready = 1'b0;
        tick();
        chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("arst_en",     {31'd0, sram_en}, 32'd0);
        chk("arst_bvalid", {31'd0, bvalid}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        rready = 1'b1;
        tick();
        rd_addr(4'd8, 32'h80, 4'd0, 2'b01);
        rd_data(4'd8, 4'd0, 1'b0);
        chk("post_rst_rdata", gd[0], 32'hAA22CC44);
        chk("post_rst_lat",   rfirst, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
